// File: rtl/turnstile_access_scheduler.sv
// Turnstile access scheduler: shares one turnstile door between NREQ card readers.
// Requests are arbitrated round-robin. The winner's code is latched and range-checked.
// A valid code opens the door for OPEN_CYCLES cycles. MAX_FAIL consecutive denials lock the
// gate out for LOCK_CYCLES cycles.
//
// Ports:
//   clk              rising-edge system clock
//   reset            asynchronous active-low reset
//   req              per-reader request level
//   code             reader i code at [i*CODE_W +: CODE_W]
//   ack              one-cycle pulse, request i accepted and code latched
//   granted          one-cycle pulse, latched code in range
//   denied           one-cycle pulse, latched code out of range
//   open_access_door door drive
//   active_id        index of the reader being served (holds last winner)
//   locked           high for the whole lockout period
//   state_out        current state encoding
module turnstile_access_scheduler #(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned CODE_W      = 4,
   parameter int unsigned CODE_LO     = 4,
   parameter int unsigned CODE_HI     = 11,
   parameter int unsigned OPEN_CYCLES = 16,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCK_CYCLES = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*CODE_W-1:0]  code,
   output logic [NREQ-1:0]         ack,
   output logic                    granted,
   output logic                    denied,
   output logic                    open_access_door,
   output logic [$clog2(NREQ)-1:0] active_id,
   output logic                    locked,
   output logic [2:0]              state_out
);

   localparam int unsigned IdW    = $clog2(NREQ);
   localparam int unsigned MaxCyc = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int unsigned TimerW = $clog2(MaxCyc + 1);
   localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);

   localparam logic [TimerW-1:0] OpenLast = TimerW'(OPEN_CYCLES - 1);
   localparam logic [TimerW-1:0] LockLast = TimerW'(LOCK_CYCLES - 1);
   localparam logic [FailW-1:0]  FailMax  = FailW'(MAX_FAIL);
   localparam logic [CODE_W-1:0] CodeLo   = CODE_W'(CODE_LO);
   localparam logic [CODE_W-1:0] CodeHi   = CODE_W'(CODE_HI);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StCheck   = 3'd1,
      StOpen    = 3'd2,
      StDeny    = 3'd3,
      StLockout = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [IdW-1:0]      rr_q, rr_d;
   logic [IdW-1:0]      id_q, id_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [FailW-1:0]    fail_q, fail_d;
   logic [TimerW-1:0]   timer_q, timer_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic                granted_q, granted_d;
   logic                denied_q, denied_d;
   logic                door_q, door_d;
   logic                locked_q, locked_d;

   logic [IdW-1:0]      win_idx;
   logic                win_found;
   logic                code_ok;

   // Round-robin: scan starting one past the last winner, wrapping.
   always_comb begin
      win_idx   = rr_q;
      win_found = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         if (!win_found && req[IdW'((32'(rr_q) + i) % NREQ)]) begin
            win_found = 1'b1;
            win_idx   = IdW'((32'(rr_q) + i) % NREQ);
         end
      end
   end

   assign code_ok = (code_q >= CodeLo) && (code_q <= CodeHi);

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      id_d      = id_q;
      code_d    = code_q;
      fail_d    = fail_q;
      timer_d   = timer_q;
      ack_d     = '0;
      granted_d = 1'b0;
      denied_d  = 1'b0;
      door_d    = door_q;
      locked_d  = locked_q;

      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d        = StCheck;
               rr_d           = win_idx;
               id_d           = win_idx;
               code_d         = code[32'(win_idx) * CODE_W +: CODE_W];
               ack_d[win_idx] = 1'b1;
            end
         end
         StCheck: begin
            if (code_ok) begin
               state_d   = StOpen;
               granted_d = 1'b1;
               fail_d    = '0;
               timer_d   = '0;
               door_d    = 1'b1;
            end else begin
               state_d  = StDeny;
               denied_d = 1'b1;
               if (fail_q != FailMax) begin
                  fail_d = fail_q + 1'b1;
               end
            end
         end
         StOpen: begin
            if (timer_q == OpenLast) begin
               state_d = StIdle;
               door_d  = 1'b0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StDeny: begin
            if (fail_q == FailMax) begin
               state_d  = StLockout;
               locked_d = 1'b1;
               timer_d  = '0;
            end else begin
               state_d = StIdle;
            end
         end
         StLockout: begin
            // Requests are not looked at here; readers keep waiting.
            if (timer_q == LockLast) begin
               state_d  = StIdle;
               locked_d = 1'b0;
               fail_d   = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d  = StIdle;
            door_d   = 1'b0;
            locked_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         rr_q      <= IdW'(NREQ - 1);
         id_q      <= '0;
         code_q    <= '0;
         fail_q    <= '0;
         timer_q   <= '0;
         ack_q     <= '0;
         granted_q <= 1'b0;
         denied_q  <= 1'b0;
         door_q    <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         id_q      <= id_d;
         code_q    <= code_d;
         fail_q    <= fail_d;
         timer_q   <= timer_d;
         ack_q     <= ack_d;
         granted_q <= granted_d;
         denied_q  <= denied_d;
         door_q    <= door_d;
         locked_q  <= locked_d;
      end
   end

   assign ack              = ack_q;
   assign granted          = granted_q;
   assign denied           = denied_q;
   assign open_access_door = door_q;
   assign active_id        = id_q;
   assign locked           = locked_q;
   assign state_out        = state_q;

endmodule

// File: tb/tb_turnstile_access_scheduler.sv
// Testbench for turnstile_access_scheduler: directed scenarios plus a randomized run
// checked against a timeline-based reference model of the access rules.
module tb_turnstile_access_scheduler;

   localparam int unsigned NREQ        = 2;
   localparam int unsigned CODE_W      = 4;
   localparam int unsigned CODE_LO     = 4;
   localparam int unsigned CODE_HI     = 11;
   localparam int unsigned OPEN_CYCLES = 16;
   localparam int unsigned MAX_FAIL    = 3;
   localparam int unsigned LOCK_CYCLES = 32;
   localparam int unsigned IDW         = $clog2(NREQ);
   localparam int unsigned RING        = 64;
   localparam int unsigned VW          = NREQ + 4 + 3 + IDW;

   logic                   clk;
   logic                   reset;
   logic [NREQ-1:0]        req;
   logic [NREQ*CODE_W-1:0] code;
   logic [NREQ-1:0]        ack;
   logic                   granted;
   logic                   denied;
   logic                   open_access_door;
   logic [IDW-1:0]         active_id;
   logic                   locked;
   logic [2:0]             state_out;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   turnstile_access_scheduler #(
      .NREQ(NREQ), .CODE_W(CODE_W), .CODE_LO(CODE_LO), .CODE_HI(CODE_HI),
      .OPEN_CYCLES(OPEN_CYCLES), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .code(code), .ack(ack), .granted(granted),
      .denied(denied), .open_access_door(open_access_door), .active_id(active_id),
      .locked(locked), .state_out(state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each accepted request books a timeline of expected outputs.
   // Slot s is the interval following clock edge s.
   logic [NREQ-1:0] r_ack  [RING];
   bit              r_gr   [RING];
   bit              r_dn   [RING];
   bit              r_door [RING];
   bit              r_lock [RING];
   logic [2:0]      r_st   [RING];
   bit              r_idv  [RING];
   logic [IDW-1:0]  r_id   [RING];

   logic [NREQ-1:0] exp_ack;
   bit              exp_gr, exp_dn, exp_door, exp_lock;
   logic [2:0]      exp_st;
   logic [IDW-1:0]  m_id;
   int unsigned     m_rr, m_fail, m_free_at, slot;

   task automatic clear_slot(input int unsigned i);
      r_ack[i] = '0; r_gr[i] = 0; r_dn[i] = 0; r_door[i] = 0; r_lock[i] = 0;
      r_st[i] = 3'd0; r_idv[i] = 0; r_id[i] = '0;
   endtask

   task automatic model_reset();
      for (int unsigned i = 0; i < RING; i++) clear_slot(i);
      m_rr = NREQ - 1; m_fail = 0; m_free_at = 0; m_id = '0;
      exp_ack = '0; exp_gr = 0; exp_dn = 0; exp_door = 0; exp_lock = 0; exp_st = 3'd0;
   endtask

   // Advance one clock: let the model see the edge's inputs, then sample the DUT at +1.
   task automatic tick();
      int unsigned k;
      k = slot + 1;
      if (reset && (k >= m_free_at) && (req != '0)) begin
         int unsigned w;
         bit found;
         logic [CODE_W-1:0] c;
         found = 0; w = 0;
         for (int unsigned j = 1; j <= NREQ; j++) begin
            int unsigned cand;
            cand = (m_rr + j) % NREQ;
            if (!found && req[cand]) begin found = 1; w = cand; end
         end
         c = code[w*CODE_W +: CODE_W];
         m_rr = w;
         r_ack[k % RING][w] = 1'b1;
         r_st[k % RING]     = 3'd1;
         r_idv[k % RING]    = 1;
         r_id[k % RING]     = IDW'(w);
         if (c >= CODE_LO && c <= CODE_HI) begin
            m_fail = 0;
            r_gr[(k + 1) % RING] = 1;
            for (int unsigned s = k + 1; s <= k + OPEN_CYCLES; s++) begin
               r_door[s % RING] = 1; r_st[s % RING] = 3'd2;
            end
            m_free_at = k + 2 + OPEN_CYCLES;
         end else begin
            m_fail = (m_fail < MAX_FAIL) ? m_fail + 1 : MAX_FAIL;
            r_dn[(k + 1) % RING] = 1;
            r_st[(k + 1) % RING] = 3'd3;
            if (m_fail == MAX_FAIL) begin
               for (int unsigned s = k + 2; s <= k + 1 + LOCK_CYCLES; s++) begin
                  r_lock[s % RING] = 1; r_st[s % RING] = 3'd4;
               end
               m_fail = 0;
               m_free_at = k + 3 + LOCK_CYCLES;
            end else begin
               m_free_at = k + 3;
            end
         end
      end
      @(posedge clk);
      slot = k;
      #1;
      exp_ack = r_ack[k % RING]; exp_gr = r_gr[k % RING]; exp_dn = r_dn[k % RING];
      exp_door = r_door[k % RING]; exp_lock = r_lock[k % RING]; exp_st = r_st[k % RING];
      if (r_idv[k % RING]) m_id = r_id[k % RING];
      clear_slot(k % RING);
   endtask

   task automatic do_reset();
      req = '0;
      reset = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One request from a single reader; reports what was observed until the DUT is idle again.
   task automatic run_one(input int unsigned rdr, input int unsigned cval, input bit hold,
                          output bit acked, output bit gr, output bit dn,
                          output int unsigned door_n, output int unsigned lock_n,
                          output int unsigned extra_acks, output bit timeout);
      req = '0;
      req[rdr] = 1'b1;
      code[rdr*CODE_W +: CODE_W] = CODE_W'(cval);
      tick();
      acked = ack[rdr] && (state_out == 3'd1);
      if (!hold) req = '0;
      tick();
      gr = granted; dn = denied;
      door_n = 0; lock_n = 0; extra_acks = 0; timeout = 1;
      for (int i = 0; i < 100; i++) begin
         if (state_out == 3'd0) begin timeout = 0; break; end
         if (open_access_door) door_n++;
         if (locked) lock_n++;
         if (ack != '0) extra_acks++;
         tick();
      end
      req = '0;
   endtask

   task automatic test_reset();
      logic [VW-1:0] got;
      #1 reset = 1'b0;
      #1;
      got = {ack, granted, denied, open_access_door, locked, state_out, active_id};
      n_checks++;
      if (got !== '0) begin
         n_errors++; $display("FAIL reset_outputs got=%h exp=0", got);
      end
      do_reset();
   endtask

   task automatic test_single();
      bit a, g, d, t;
      int unsigned dn, ln, ea;
      do_reset();
      run_one(0, 5, 0, a, g, d, dn, ln, ea, t);
      n_checks++; if (a !== 1'b1) begin n_errors++; $display("FAIL single_ack got=%0d exp=1", a); end
      n_checks++; if (g !== 1'b1) begin n_errors++; $display("FAIL single_grant got=%0d exp=1", g); end
      n_checks++; if (d !== 1'b0) begin n_errors++; $display("FAIL single_deny got=%0d exp=0", d); end
      n_checks++;
      if (dn != OPEN_CYCLES) begin
         n_errors++; $display("FAIL single_door_cycles got=%0d exp=%0d", dn, OPEN_CYCLES);
      end
      n_checks++; if (t) begin n_errors++; $display("FAIL single_idle got=timeout exp=idle"); end
   endtask

   task automatic test_round_robin();
      int unsigned winners[$];
      do_reset();
      req = 2'b11;
      code = {4'd9, 4'd5};
      for (int i = 0; i < 120 && winners.size() < 4; i++) begin
         tick();
         if (ack != '0) winners.push_back(ack[1] ? 1 : 0);
      end
      req = '0;
      n_checks++;
      if (winners.size() != 4) begin
         n_errors++; $display("FAIL rr_count got=%0d exp=4", winners.size());
      end
      for (int i = 0; i < winners.size(); i++) begin
         n_checks++;
         if (winners[i] != i % 2) begin
            n_errors++; $display("FAIL rr_winner_%0d got=%0d exp=%0d", i, winners[i], i % 2);
         end
      end
   endtask

   task automatic test_boundaries();
      int unsigned codes[4] = '{3, 12, 4, 11};
      bit          ok[4]    = '{0, 0, 1, 1};
      bit a, g, d, t;
      int unsigned dn, ln, ea;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_one(i % 2, codes[i], 0, a, g, d, dn, ln, ea, t);
         n_checks++;
         if (g !== ok[i] || d !== !ok[i]) begin
            n_errors++; $display("FAIL bound_code%0d got=g%0d/d%0d exp=g%0d", codes[i], g, d, ok[i]);
         end
         n_checks++;
         if (dn != (ok[i] ? OPEN_CYCLES : 0)) begin
            n_errors++; $display("FAIL bound_door%0d got=%0d exp=%0d", codes[i], dn,
                                 ok[i] ? OPEN_CYCLES : 0);
         end
         n_checks++;
         if (ln != 0 || t) begin
            n_errors++; $display("FAIL bound_nolock%0d got=%0d exp=0", codes[i], ln);
         end
      end
   endtask

   task automatic test_lockout();
      bit a, g, d, t;
      int unsigned dn, ln, ea;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_one(0, 2, 1, a, g, d, dn, ln, ea, t);
         n_checks++;
         if (ln != (i == 2 ? LOCK_CYCLES : 0) || !d) begin
            n_errors++; $display("FAIL lock_deny%0d got=lock%0d exp=%0d", i, ln,
                                 i == 2 ? LOCK_CYCLES : 0);
         end
      end
      n_checks++;
      if (ea != 0 || t) begin n_errors++; $display("FAIL lock_no_ack got=%0d exp=0", ea); end
      run_one(0, 13, 0, a, g, d, dn, ln, ea, t);
      n_checks++;
      if (ln != 0 || !d) begin
         n_errors++; $display("FAIL lock_fail_cleared got=lock%0d exp=0", ln);
      end
      run_one(1, 7, 0, a, g, d, dn, ln, ea, t);
      n_checks++;
      if (!a || !g) begin n_errors++; $display("FAIL lock_then_grant got=a%0d/g%0d exp=1/1", a, g); end
   endtask

   task automatic test_fail_clear();
      int unsigned codes[5] = '{3, 4, 12, 0, 15};
      int unsigned exp_l[5] = '{0, 0, 0, 0, LOCK_CYCLES};
      bit a, g, d, t;
      int unsigned dn, ln, ea;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_one(0, codes[i], 0, a, g, d, dn, ln, ea, t);
         n_checks++;
         if (ln != exp_l[i]) begin
            n_errors++; $display("FAIL clear_seq%0d got=lock%0d exp=%0d", i, ln, exp_l[i]);
         end
      end
   endtask

   task automatic test_reset_mid_open();
      logic [VW-1:0] got;
      do_reset();
      req = 2'b01;
      code = {4'd6, 4'd5};
      tick();
      req = '0;
      repeat (5) tick();
      n_checks++;
      if (open_access_door !== 1'b1) begin
         n_errors++; $display("FAIL midreset_pre_door got=%0d exp=1", open_access_door);
      end
      #2 reset = 1'b0;
      #1;
      got = {ack, granted, denied, open_access_door, locked, state_out, active_id};
      n_checks++;
      if (got !== '0) begin n_errors++; $display("FAIL midreset_outputs got=%h exp=0", got); end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      req = 2'b11;
      tick();
      req = '0;
      n_checks++;
      if (ack !== 2'b01) begin n_errors++; $display("FAIL midreset_first_win got=%b exp=01", ack); end
   endtask

   task automatic test_random();
      logic [VW-1:0] got, expv;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         for (int r = 0; r < NREQ; r++) code[r*CODE_W +: CODE_W] = CODE_W'($urandom_range(0, 15));
         tick();
         got  = {ack, granted, denied, open_access_door, locked, state_out, active_id};
         expv = {exp_ack, exp_gr, exp_dn, exp_door, exp_lock, exp_st, m_id};
         n_checks++;
         if (got !== expv) begin
            n_errors++; $display("FAIL random_cycle%0d got=%h exp=%h", i, got, expv);
         end
      end
      req = '0;
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      code  = '0;
      slot  = 0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_boundaries();
      test_lockout();
      test_fail_clear();
      test_reset_mid_open();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
